clarvi_rf_write_sequencer: RTL

- Write-side front end for the split-half register file. The register file stores 64-bit registers and is written 32 bits per cycle, selected by write_part.
- Accepts whole 64-bit (wide) or 32-bit (narrow) writeback results over a valid/ready handshake and buffers them in a small FIFO.
- Issues each result as one or two half-writes: low half first, then high half.
- Sits between the execute/writeback stage and the register file write port. Exports a pending-register mask for hazard detection.

---
 rtl/clarvi_rf_write_sequencer_pkg.sv | 28 ++
 rtl/clarvi_rf_write_sequencer_sync_fifo.sv | 82 ++++++++
 rtl/clarvi_rf_write_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/clarvi_rf_write_sequencer_pkg.sv
// Shared types for the register-file write sequencer.
// Entry layout {rd, data, wide}, FSM states, pending-mask helper.
package clarvi_rf_write_sequencer_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        wide;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_LO,
    WB_HI
  } wb_state_t;

  localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);
  localparam int unsigned WB_RD_W    = 5;
  localparam int unsigned WB_RD_LSB  = WB_ENTRY_W - WB_RD_W;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    logic [31:0] m;
    m = 32'd0;
    if (rd != 5'd0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/clarvi_rf_write_sequencer_sync_fifo.sv
// Synchronous FIFO with per-slot valid bits and a tag slice per slot.
// Ports: push/din, pop/head, full/empty, valid[], tags[] (TAG_W bits at TAG_LSB).
module clarvi_sync_fifo #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TAG_W   = 1,
  parameter int unsigned TAG_LSB = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [WIDTH-1:0]             head,
  output logic [DEPTH-1:0]             valid,
  output logic [DEPTH-1:0][TAG_W-1:0]  tags
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        push_en, pop_en;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign valid   = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tags[i] = mem_q[i][TAG_LSB +: TAG_W];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q]   = din;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/clarvi_rf_write_sequencer.sv
// Splits 64/32-bit writeback results into low/high 32-bit RF writes.
// Ports: in_* handshake, write_* RF port, pending_mask, busy.
module clarvi_rf_write_sequencer
  import clarvi_rf_write_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_data,
  input  logic        in_wide,
  output logic        write_enable,
  output logic        write_part,
  output logic [4:0]  write_register,
  output logic [31:0] data_in,
  output logic [31:0] pending_mask,
  output logic        busy
);

  wb_entry_t                       in_entry, head, work_q, work_d;
  wb_state_t                       state_q, state_d;
  logic                            push, pop, full, empty, active;
  logic [DEPTH-1:0]                valid;
  logic [DEPTH-1:0][WB_RD_W-1:0]   tags;
  logic                            part_q, part_d;
  logic [4:0]                      reg_q, reg_d;
  logic [31:0]                     din_q, din_d;

  assign in_entry = '{rd: in_rd, data: in_data, wide: in_wide};
  // rd==0 is accepted but never stored
  assign push     = in_valid && !full && (in_rd != 5'd0);
  assign in_ready = !full;
  assign active   = (state_q != WB_IDLE);
  assign busy     = !empty || active;

  clarvi_sync_fifo #(
    .WIDTH   (WB_ENTRY_W),
    .DEPTH   (DEPTH),
    .TAG_W   (WB_RD_W),
    .TAG_LSB (WB_RD_LSB)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (in_entry),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head),
    .valid (valid),
    .tags  (tags)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    pop     = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          work_d  = head;
          state_d = WB_LO;
        end
      end
      WB_LO: begin
        if (work_q.wide) begin
          state_d = WB_HI;
        end else if (!empty) begin
          pop     = 1'b1;
          work_d  = head;
          state_d = WB_LO;
        end else begin
          state_d = WB_IDLE;
        end
      end
      WB_HI: begin
        if (!empty) begin
          pop     = 1'b1;
          work_d  = head;
          state_d = WB_LO;
        end else begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // idle cycles replay the last driven part/index/data
  always_comb begin
    write_enable   = active;
    write_part     = part_q;
    write_register = reg_q;
    data_in        = din_q;
    if (active) begin
      write_part     = (state_q == WB_HI);
      write_register = work_q.rd;
      data_in        = (state_q == WB_HI) ? work_q.data[63:32]
                                          : work_q.data[31:0];
    end
    part_d = write_part;
    reg_d  = write_register;
    din_d  = data_in;
  end

  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pending_mask = pending_mask | rd_onehot(tags[i]);
    end
    if (active) pending_mask = pending_mask | rd_onehot(work_q.rd);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WB_IDLE;
      work_q  <= '0;
      part_q  <= 1'b0;
      reg_q   <= 5'd0;
      din_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      part_q  <= part_d;
      reg_q   <= reg_d;
      din_q   <= din_d;
    end
  end

endmodule
